// File: rtl/sync_frame_pkg.sv
// -----------------------------------------------------------------------------
// sync_frame_pkg
// Shared types and helpers for the sync_frame_tx serial framer.
//   state_t          : FSM state encoding (idle, sync word, payload, parity,
//                      idle-zero gap)
//   SYNC_PAT_DEFAULT : default 5-bit sync word 11011
//   frame_len()      : number of frame bits (sync + data + optional parity)
//   max3()           : largest of three ints, used to size the bit counter
// -----------------------------------------------------------------------------
package sync_frame_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_DATA = 3'd2,
    S_PAR  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam logic [4:0] SYNC_PAT_DEFAULT = 5'b11011;

  function automatic int frame_len(input int sync_w, input int data_w,
                                   input int parity_en);
    return sync_w + data_w + ((parity_en != 0) ? 1 : 0);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync_frame_piso.sv
// -----------------------------------------------------------------------------
// sync_frame_piso
// Loadable MSB-first parallel-in / serial-out shift register.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, clears the register
//   load  : capture din (takes priority over shift)
//   shift : move every bit one place toward the MSB, a 0 enters at the LSB
//   din   : parallel word, MSB is the first bit sent
//   msb   : current serial bit, taken straight from the register MSB
//
// Zeros are shifted in at the LSB, so once a full word has been shifted out
// the register is all-zero and msb idles low without any extra gating.
// -----------------------------------------------------------------------------
module sync_frame_piso #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= sreg << 1;
    end
  end

  assign msb = sreg[W-1];

endmodule

// File: rtl/sync_frame_tx.sv
// -----------------------------------------------------------------------------
// sync_frame_tx
// Serial frame transmitter: sync word, payload (MSB first), optional even
// parity bit, then GAP idle zeros so downstream sync detectors re-arm.
//
// State table
//   state  | meaning
//   S_IDLE | ready for a payload, in_ready=1
//   S_SYNC | sending the SYNC_W sync bits
//   S_DATA | sending the DATA_W payload bits
//   S_PAR  | sending the even-parity bit (only when PARITY_EN=1)
//   S_GAP  | GAP cycles of out=0, out_en=0 before returning to idle
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_data    : payload, captured only on acceptance
//   in_valid   : payload offered
//   in_ready   : high in S_IDLE, forced low while rst is asserted
//   out        : serial bit (flop), 0 outside a frame
//   out_en     : high while out carries a frame bit (flop)
//   frame_done : one-cycle pulse with the last frame bit (flop)
// -----------------------------------------------------------------------------
module sync_frame_tx
  import sync_frame_pkg::*;
#(
  parameter int                SYNC_W    = 5,
  parameter logic [SYNC_W-1:0] SYNC_PAT  = SYNC_W'(SYNC_PAT_DEFAULT),
  parameter int                DATA_W    = 8,
  parameter int                PARITY_EN = 1,
  parameter int                GAP       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out,
  output logic              out_en,
  output logic              frame_done
);

  localparam int L       = frame_len(SYNC_W, DATA_W, PARITY_EN);
  localparam int CNT_MAX = max3(SYNC_W, DATA_W, GAP);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Counter reload values: a state lasting N cycles is entered with N-1 and
  // left when the counter reads 0, so it never has to wrap.
  localparam logic [CNT_W-1:0] SYNC_LD = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LD = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP - 1);

  // State that carries the final frame bit.
  localparam state_t LAST_ST = (PARITY_EN != 0) ? S_PAR : S_DATA;

  if (SYNC_W < 1) begin : g_bad_sync_w
    $error("sync_frame_tx: SYNC_W must be at least 1");
  end
  if (DATA_W < 1) begin : g_bad_data_w
    $error("sync_frame_tx: DATA_W must be at least 1");
  end
  if (GAP < 1) begin : g_bad_gap
    $error("sync_frame_tx: GAP must be at least 1");
  end

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             accept;
  logic             load, shift;
  logic             out_en_d, frame_done_d;
  logic [L-1:0]     frame_word;

  assign accept = in_valid && (state == S_IDLE);

  if (PARITY_EN != 0) begin : g_par
    assign frame_word = {SYNC_PAT, in_data, ^in_data};
  end else begin : g_nopar
    assign frame_word = {SYNC_PAT, in_data};
  end

  // ---------------------------------------------------------------------------
  // State register and bit counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and counter reload
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = S_SYNC;
          cnt_d   = SYNC_LD;
        end
      end
      S_SYNC: begin
        if (cnt == '0) begin
          state_d = S_DATA;
          cnt_d   = DATA_LD;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == '0) begin
          if (PARITY_EN != 0) begin
            state_d = S_PAR;
            cnt_d   = '0;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_LD;
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_PAR: begin
        state_d = S_GAP;
        cnt_d   = GAP_LD;
      end
      S_GAP: begin
        if (cnt == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // out_en and frame_done are registered from the *next* state so they line
  // up with the bit the shift register presents in the following cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    load         = accept;
    shift        = (state == S_SYNC) || (state == S_DATA) || (state == S_PAR);
    out_en_d     = (state_d == S_SYNC) || (state_d == S_DATA) ||
                   (state_d == S_PAR);
    frame_done_d = (state_d == LAST_ST) && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_en     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_en     <= out_en_d;
      frame_done <= frame_done_d;
    end
  end

  assign in_ready = (state == S_IDLE) && !rst;

  // The register is loaded with exactly L bits and shifted once per frame bit,
  // so it is empty (out=0) by the time the gap starts.
  sync_frame_piso #(
    .W (L)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (frame_word),
    .msb   (out)
  );

endmodule

// File: tb/tb_sync_frame_tx.sv
module tb_sync_frame_tx;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] in_data_a, in_data_np;
  logic       in_valid_a, in_valid_np;
  logic       in_ready_a, in_ready_np;
  logic       out_a, out_np;
  logic       out_en_a, out_en_np;
  logic       frame_done_a, frame_done_np;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_on   = 0;
  exp_t sb_q[$];

  sync_frame_tx dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data_a),
    .in_valid   (in_valid_a),
    .in_ready   (in_ready_a),
    .out        (out_a),
    .out_en     (out_en_a),
    .frame_done (frame_done_a)
  );

  sync_frame_tx #(.PARITY_EN(0)) dut_np (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data_np),
    .in_valid   (in_valid_np),
    .in_ready   (in_ready_np),
    .out        (out_np),
    .out_en     (out_en_np),
    .frame_done (frame_done_np)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
    $fatal(1);
  end

  // 11011 non-overlapping detector: state = matched prefix length.
  function automatic void det_step(input int s, input logic b,
                                   output int ns, output logic hit);
    hit = 1'b0;
    ns  = 0;
    case (s)
      0: ns = b ? 1 : 0;
      1: ns = b ? 2 : 0;
      2: ns = b ? 2 : 3;
      3: ns = b ? 4 : 0;
      4: begin hit = b; ns = 0; end
      default: ns = 0;
    endcase
  endfunction

  task automatic push_frame(input logic [7:0] d);
    logic [4:0] sp;
    exp_t e;
    sp = 5'b11011;
    for (int i = 4; i >= 0; i--) begin e.b = sp[i]; e.last = 1'b0; sb_q.push_back(e); end
    for (int i = 7; i >= 0; i--) begin e.b = d[i];  e.last = 1'b0; sb_q.push_back(e); end
    e.b = ^d; e.last = 1'b1;
    sb_q.push_back(e);
  endtask

  task automatic scoreboard_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (out_en_a === 1'b1) begin
          n_checks++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: out_en=1 with no expected bit, out=%b", out_a);
          end else begin
            e = sb_q.pop_front();
            if (out_a !== e.b) begin
              n_fail++;
              $display("FAIL sb_bit: out=%b expected %b at %0t", out_a, e.b, $time);
            end
            n_checks++;
            if (frame_done_a !== e.last) begin
              n_fail++;
              $display("FAIL sb_frame_done: frame_done=%b expected %b at %0t", frame_done_a, e.last, $time);
            end
          end
        end else begin
          n_checks++;
          if (out_a !== 1'b0 || frame_done_a !== 1'b0 || out_en_a !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_idle: out=%b out_en=%b frame_done=%b expected 0 0 0 at %0t", out_a, out_en_a, frame_done_a, $time);
          end
        end
      end
    end
  endtask

  task automatic send_a(input logic [7:0] d);
    int k;
    k = 0;
    while (in_ready_a !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    n_checks++;
    if (in_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b expected 1 within 100 cycles", in_ready_a);
    end
    in_valid_a = 1'b1;
    in_data_a  = d;
    @(posedge clk);
    push_frame(d);
    #1;
    in_valid_a = 1'b0;
    in_data_a  = ~d;
  endtask

  task automatic wait_idle_a();
    int k;
    k = 0;
    while (in_ready_a !== 1'b1 && k < 100) begin @(negedge clk); k++; end
    n_checks++;
    if (in_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_timeout: in_ready=%b expected 1 within 100 cycles", in_ready_a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid_a = 1'b0; in_data_a = 8'h00;
    in_valid_np = 1'b0; in_data_np = 8'h00;
    #2;
    n_checks++;
    if ({out_a, out_en_a, frame_done_a, in_ready_a} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: out/out_en/frame_done/in_ready=%b expected 0000",
               {out_a, out_en_a, frame_done_a, in_ready_a});
    end
    n_checks++;
    if ({out_np, out_en_np, frame_done_np, in_ready_np} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs_np: got %b expected 0000",
               {out_np, out_en_np, frame_done_np, in_ready_np});
    end
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready_a !== 1'b1 || in_ready_np !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: in_ready a=%b np=%b expected 1 1", in_ready_a, in_ready_np);
    end
    mon_on = 1;
  endtask

  task automatic test_basic();
    logic [13:0] exp_bits;
    exp_bits = 14'b11011101001010;
    send_a(8'hA5);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_a !== ((c <= 14) ? exp_bits[14-c] : 1'b0)) begin
        n_fail++;
        $display("FAIL basic_out c=%0d: out=%b expected %b", c, out_a, (c <= 14) ? exp_bits[14-c] : 1'b0);
      end
      n_checks++;
      if (out_en_a !== (c <= 14)) begin
        n_fail++;
        $display("FAIL basic_out_en c=%0d: out_en=%b expected %b", c, out_en_a, c <= 14);
      end
      n_checks++;
      if (frame_done_a !== (c == 14)) begin
        n_fail++;
        $display("FAIL basic_frame_done c=%0d: frame_done=%b expected %b", c, frame_done_a, c == 14);
      end
      n_checks++;
      if (in_ready_a !== (c == 17)) begin
        n_fail++;
        $display("FAIL basic_in_ready c=%0d: in_ready=%b expected %b", c, in_ready_a, c == 17);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0] d [2];
    logic       p [2];
    d[0] = 8'h01; p[0] = 1'b1;
    d[1] = 8'hFF; p[1] = 1'b0;
    for (int t = 0; t < 2; t++) begin
      send_a(d[t]);
      repeat (14) @(negedge clk);
      n_checks++;
      if (out_a !== p[t] || frame_done_a !== 1'b1) begin
        n_fail++;
        $display("FAIL parity_%02h: out=%b frame_done=%b expected %b 1", d[t], out_a, frame_done_a, p[t]);
      end
    end
    wait_idle_a();
  endtask

  task automatic test_no_parity();
    logic [12:0] exp_bits;
    exp_bits = 13'b1101100111100;
    n_checks++;
    if (in_ready_np !== 1'b1) begin
      n_fail++;
      $display("FAIL np_ready_start: in_ready=%b expected 1", in_ready_np);
    end
    in_valid_np = 1'b1;
    in_data_np  = 8'h3C;
    @(posedge clk);
    #1;
    in_valid_np = 1'b0;
    in_data_np  = 8'hFF;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_np !== ((c <= 13) ? exp_bits[13-c] : 1'b0) || out_en_np !== (c <= 13)) begin
        n_fail++;
        $display("FAIL np_out c=%0d: out=%b out_en=%b expected %b %b", c, out_np, out_en_np,
                 (c <= 13) ? exp_bits[13-c] : 1'b0, c <= 13);
      end
      n_checks++;
      if (frame_done_np !== (c == 13)) begin
        n_fail++;
        $display("FAIL np_frame_done c=%0d: frame_done=%b expected %b", c, frame_done_np, c == 13);
      end
      n_checks++;
      if (in_ready_np !== (c == 16)) begin
        n_fail++;
        $display("FAIL np_in_ready c=%0d: in_ready=%b expected %b", c, in_ready_np, c == 16);
      end
    end
  endtask

  task automatic test_back_to_back();
    wait_idle_a();
    in_valid_a = 1'b1;
    in_data_a  = 8'h11;
    @(posedge clk);
    push_frame(8'h11);
    #1 in_data_a = 8'hEE;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      if (c == 8) in_data_a = 8'h22;
      n_checks++;
      if (in_ready_a !== (c == 17)) begin
        n_fail++;
        $display("FAIL b2b_in_ready c=%0d: in_ready=%b expected %b", c, in_ready_a, c == 17);
      end
    end
    @(posedge clk);
    push_frame(8'h22);
    #1;
    in_valid_a = 1'b0;
    in_data_a  = 8'h00;
    @(negedge clk);
    n_checks++;
    if (out_en_a !== 1'b1 || out_a !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_start c=18: out_en=%b out=%b expected 1 1", out_en_a, out_a);
    end
    wait_idle_a();
  endtask

  task automatic test_reset_abort();
    int fd_seen;
    send_a(8'h5A);
    repeat (7) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_a, out_en_a, frame_done_a, in_ready_a} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_async_clear: out/out_en/frame_done/in_ready=%b expected 0000",
               {out_a, out_en_a, frame_done_a, in_ready_a});
    end
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready_a !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ready_in_rst: in_ready=%b expected 0", in_ready_a);
    end
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_ready_release: in_ready=%b expected 1", in_ready_a);
    end
    fd_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (frame_done_a === 1'b1) fd_seen++;
    end
    n_checks++;
    if (fd_seen != 0) begin
      n_fail++;
      $display("FAIL abort_no_frame_done: frame_done pulses=%0d expected 0", fd_seen);
    end
    send_a(8'hC3);
    repeat (14) @(negedge clk);
    n_checks++;
    if (frame_done_a !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_next_frame_done: frame_done=%b expected 1 in cycle 14", frame_done_a);
    end
    wait_idle_a();
  endtask

  task automatic test_loopback();
    int         obs_s, ref_s, ns;
    logic       hit;
    logic [7:0] d;
    logic [4:0] sp;
    logic [15:0] stream, exp_mask, obs_mask;
    int         total;
    sp    = 5'b11011;
    obs_s = 0;
    total = 0;
    for (int f = 0; f < 100; f++) begin
      d = 8'($urandom_range(0, 255));
      stream = '0;
      for (int i = 0; i < 5; i++) stream[i] = sp[4-i];
      for (int i = 0; i < 8; i++) stream[5+i] = d[7-i];
      stream[13] = ^d;
      ref_s    = 0;
      exp_mask = '0;
      for (int i = 0; i < 16; i++) begin
        det_step(ref_s, stream[i], ns, hit);
        ref_s = ns;
        exp_mask[i] = hit;
      end
      send_a(d);
      obs_mask = '0;
      for (int c = 1; c <= 16; c++) begin
        @(negedge clk);
        det_step(obs_s, out_a, ns, hit);
        obs_s = ns;
        obs_mask[c-1] = hit;
      end
      n_checks++;
      if (obs_mask[4] !== 1'b1) begin
        n_fail++;
        $display("FAIL loop_sync_detect f=%0d data=%02h: detect at sync bit 5=%b expected 1", f, d, obs_mask[4]);
      end
      n_checks++;
      if (obs_mask !== exp_mask) begin
        n_fail++;
        $display("FAIL loop_detect_mask f=%0d data=%02h: mask=%04h expected %04h", f, d, obs_mask, exp_mask);
      end
      for (int i = 0; i < 16; i++) total += int'(obs_mask[i]);
    end
    n_checks++;
    if (total < 100) begin
      n_fail++;
      $display("FAIL loop_total: detections=%0d expected at least 100", total);
    end
    wait_idle_a();
  endtask

  initial begin
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_basic();
    test_parity();
    test_no_parity();
    test_back_to_back();
    test_reset_abort();
    test_loopback();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expected bits never seen, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
